simon_round_ctrl: RTL

Round sequencer for the Simon game. Owns the growing colour sequence, plays it back on the four LEDs, then checks the player's button presses against it, in timeout-guarded rounds, until the player misses or completes `MAX_LEN` steps. Sits between the button debouncers and the LED/buzzer drivers, clocked by the 60 Hz game tick.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_lfsr.sv | 28 ++
 rtl/simon_round_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon round sequencer.
// No logic of its own; imported by the LFSR and the round controller.
// Holds the state encoding, LFSR seed/taps and the LFSR step function.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    PAUSE,
    LOSE,
    WIN
  } state_e;

  // Seed loaded on reset; any non-zero value keeps the LFSR off the lock-up state.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit maximal-length Fibonacci LFSR used as the colour source.
// Latency: new value every cycle after reset release.
// Backpressure: none; it never stalls.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next value from the tap polynomial.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // Shift register, seeded on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round sequencer: grows the colour sequence, plays it back, checks the player.
// Latency: outputs decoded from registered state; a release is acted on at the next edge.
// Backpressure: none; inputs are levels sampled every tick, start ignored while a game runs.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter int HOLD_TICKS    = 30,
  parameter int GAP_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 300
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         player_pressed,
  input  logic [1:0]                   player_num,
  output logic                         led_on,
  output logic [1:0]                   led_num,
  output logic                         player_turn,
  output logic [$clog2(MAX_LEN+1)-1:0] round_len,
  output logic                         game_over,
  output logic                         win
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] ONE_L = LW'(1);

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [1:0]      cap_num_q;
  logic            prev_pressed_q;
  logic [1:0]      seq_q [MAX_LEN];
  logic            seq_we;
  logic [1:0]      seq_rd;
  logic [7:0]      lfsr;
  logic            lfsr_unused;
  logic            rel_evt;
  logic            last_step;

  simon_lfsr u_lfsr (
    .clk_i  (clk),
    .rst_ni (reset),
    .lfsr_o (lfsr)
  );

  // Only the two low LFSR bits pick a colour.
  assign lfsr_unused = ^lfsr[7:2];

  assign rel_evt   = prev_pressed_q & ~player_pressed;
  assign seq_rd    = seq_q[idx_q[IW-1:0]];
  assign last_step = (idx_q == (len_q - ONE_L));

  // Next-state logic for the round sequencer.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    seq_we  = 1'b0;
    case (state_q)
      IDLE, LOSE, WIN: begin
        if (start) begin
          len_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        seq_we  = 1'b1;
        len_d   = len_q + ONE_L;
        idx_d   = '0;
        tmr_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tmr_q == TW'(HOLD_TICKS - 1)) begin
          tmr_d   = '0;
          state_d = SHOW_OFF;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SHOW_OFF: begin
        if (tmr_q == TW'(GAP_TICKS - 1)) begin
          tmr_d = '0;
          if (last_step) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + ONE_L;
            state_d = SHOW_ON;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT_IN: begin
        // A release takes priority over a timeout landing in the same cycle.
        if (rel_evt) begin
          tmr_d = '0;
          if (cap_num_q != seq_rd) begin
            state_d = LOSE;
          end else if (last_step) begin
            state_d = (len_q == LW'(MAX_LEN)) ? WIN : PAUSE;
          end else begin
            idx_d = idx_q + ONE_L;
          end
        end else if (tmr_q == TW'(TIMEOUT_TICKS)) begin
          state_d = LOSE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      PAUSE: begin
        if (tmr_q == TW'(GAP_TICKS - 1)) begin
          tmr_d   = '0;
          state_d = ADD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers and release detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      tmr_q          <= '0;
      cap_num_q      <= 2'd0;
      prev_pressed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      tmr_q          <= tmr_d;
      prev_pressed_q <= player_pressed;
      if (player_pressed) cap_num_q <= player_num;
    end
  end

  // Sequence storage; always rewritten before being read, so no reset.
  always_ff @(posedge clk) begin
    if (seq_we) seq_q[len_q[IW-1:0]] <= lfsr[1:0];
  end

  // Output decode from registered state only.
  always_comb begin
    led_on      = (state_q == SHOW_ON);
    led_num     = led_on ? seq_rd : 2'd0;
    player_turn = (state_q == WAIT_IN);
    game_over   = (state_q == LOSE);
    win         = (state_q == WIN);
    round_len   = len_q;
  end

endmodule
